// File: rtl/ov7670_config_seq.sv
// Walks the OV7670 configuration ROM and issues one SCCB register write per entry.
// Optional NACK retry per entry is enabled by defining CFG_SEQ_RETRY_EN.
module ov7670_config_seq #(
   parameter int unsigned CLK_FREQ_HZ = 25_000_000,
   parameter int unsigned DELAY_MS    = 10,
   parameter logic [7:0]  SCCB_ID     = 8'h42,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [7:0]  rom_addr,
   input  logic [15:0] rom_data,
   output logic        sccb_start,
   output logic [7:0]  sccb_id,
   output logic [7:0]  sccb_reg,
   output logic [7:0]  sccb_val,
   input  logic        sccb_ready,
   input  logic        sccb_done,
   input  logic        sccb_nack,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int unsigned DELAY_CYC = (CLK_FREQ_HZ / 1000) * DELAY_MS;
   localparam int unsigned CNT_W     = (DELAY_CYC < 1) ? 1 : $clog2(DELAY_CYC + 1);

   localparam logic [15:0] WORD_END   = 16'hFFFF;
   localparam logic [15:0] WORD_DELAY = 16'hFFF0;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_WAIT_RDY, S_WAIT_DONE, S_DELAY, S_NEXT, S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [7:0]         rom_addr_q, rom_addr_d;
   logic               sccb_start_q, sccb_start_d;
   logic [7:0]         sccb_reg_q, sccb_reg_d;
   logic [7:0]         sccb_val_q, sccb_val_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               error_q, error_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

`ifdef CFG_SEQ_RETRY_EN
   localparam int unsigned RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   logic [RTY_W-1:0]   retry_q, retry_d;
`else
   logic               nack_unused;
   assign nack_unused = sccb_nack;
`endif

   always_comb begin
      state_d      = state_q;
      rom_addr_d   = rom_addr_q;
      sccb_start_d = 1'b0;
      sccb_reg_d   = sccb_reg_q;
      sccb_val_d   = sccb_val_q;
      busy_d       = busy_q;
      done_d       = done_q;
      error_d      = error_q;
      cnt_d        = cnt_q;
`ifdef CFG_SEQ_RETRY_EN
      retry_d      = retry_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               rom_addr_d = 8'd0;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               error_d    = 1'b0;
               state_d    = S_FETCH;
            end
         end
         // rom_data reflects rom_addr only one cycle after it changes
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            if (rom_data == WORD_END) begin
               state_d = S_DONE;
            end else if (rom_data == WORD_DELAY) begin
               cnt_d   = CNT_W'(DELAY_CYC);
               state_d = S_DELAY;
            end else begin
               sccb_reg_d = rom_data[15:8];
               sccb_val_d = rom_data[7:0];
`ifdef CFG_SEQ_RETRY_EN
               retry_d    = '0;
`endif
               state_d    = S_WAIT_RDY;
            end
         end
         S_WAIT_RDY: begin
            if (sccb_ready) begin
               sccb_start_d = 1'b1;
               state_d      = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (sccb_done) begin
`ifdef CFG_SEQ_RETRY_EN
               if (!sccb_nack) begin
                  state_d = S_NEXT;
               end else if (retry_q < RTY_W'(MAX_RETRY)) begin
                  retry_d = retry_q + RTY_W'(1);
                  state_d = S_WAIT_RDY;
               end else begin
                  error_d = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b0;
                  state_d = S_IDLE;
               end
`else
               state_d = S_NEXT;
`endif
            end
         end
         // Leaves after exactly DELAY_CYC cycles: exits on the cycle the count reads 1
         S_DELAY: begin
            cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) state_d = S_NEXT;
         end
         S_NEXT: begin
            if (rom_addr_q == 8'hFF) begin
               state_d = S_DONE;
            end else begin
               rom_addr_d = rom_addr_q + 8'd1;
               state_d    = S_FETCH;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         rom_addr_q   <= 8'd0;
         sccb_start_q <= 1'b0;
         sccb_reg_q   <= 8'd0;
         sccb_val_q   <= 8'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         cnt_q        <= '0;
`ifdef CFG_SEQ_RETRY_EN
         retry_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         rom_addr_q   <= rom_addr_d;
         sccb_start_q <= sccb_start_d;
         sccb_reg_q   <= sccb_reg_d;
         sccb_val_q   <= sccb_val_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
         cnt_q        <= cnt_d;
`ifdef CFG_SEQ_RETRY_EN
         retry_q      <= retry_d;
`endif
      end
   end

   assign rom_addr   = rom_addr_q;
   assign sccb_start = sccb_start_q;
   assign sccb_id    = SCCB_ID;
   assign sccb_reg   = sccb_reg_q;
   assign sccb_val   = sccb_val_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Bench for ov7670_config_seq: ROM and SCCB master models, table-walk reference model.
module tb_ov7670_config_seq;

   localparam int unsigned DC        = 5;
   localparam int unsigned MAX_RETRY = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data = 16'h0000;
   logic        sccb_start;
   logic [7:0]  sccb_id, sccb_reg, sccb_val;
   logic        sccb_ready = 1'b1;
   logic        sccb_done = 1'b0;
   logic        sccb_nack = 1'b0;
   logic        busy, done, error;

   ov7670_config_seq #(
      .CLK_FREQ_HZ(1000), .DELAY_MS(5), .SCCB_ID(8'h42), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
      .sccb_start(sccb_start), .sccb_id(sccb_id), .sccb_reg(sccb_reg), .sccb_val(sccb_val),
      .sccb_ready(sccb_ready), .sccb_done(sccb_done), .sccb_nack(sccb_nack),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   logic [15:0] rom_mem [256];
   bit          nack_mask [256];
   int          ack_lat = 0;
   logic [15:0] got_w[$];
   int          got_cyc[$];
   int          stab_err = 0;
   logic [15:0] exp_w[$];
   bit          exp_err;
   logic [7:0]  exp_addr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // SCCB master: answers each launch after ack_lat cycles, NACKing masked registers
   initial forever begin
      @(posedge clk); #1;
      sccb_done = 1'b0;
      sccb_nack = 1'b0;
      if (rst_n && sccb_start) begin
         if (ack_lat > 0) begin
            sccb_ready = 1'b0;
            repeat (ack_lat) begin @(posedge clk); #1; end
            sccb_ready = 1'b1;
         end
         sccb_done = 1'b1;
         sccb_nack = nack_mask[sccb_reg];
      end
   end

   initial begin
      bit          inflight = 1'b0;
      logic [15:0] hold = 16'h0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            inflight = 1'b0;
         end else begin
            if (sccb_start) begin
               got_w.push_back({sccb_reg, sccb_val});
               got_cyc.push_back(cyc);
               inflight = 1'b1;
               hold = {sccb_reg, sccb_val};
            end else if (inflight && ({sccb_reg, sccb_val} !== hold)) begin
               stab_err++;
            end
            if (sccb_done) inflight = 1'b0;
         end
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // Reference: the writes a table produces, read straight from the table rules
   function automatic void build_model();
      exp_w.delete();
      exp_err  = 1'b0;
      exp_addr = 8'hFF;
      for (int a = 0; a < 256; a++) begin
         if (rom_mem[a] == 16'hFFFF) begin
            exp_addr = 8'(a);
            break;
         end
         if (rom_mem[a] != 16'hFFF0) begin
`ifdef CFG_SEQ_RETRY_EN
            if (nack_mask[rom_mem[a][15:8]]) begin
               for (int r = 0; r <= int'(MAX_RETRY); r++) exp_w.push_back(rom_mem[a]);
               exp_err  = 1'b1;
               exp_addr = 8'(a);
               break;
            end
`endif
            exp_w.push_back(rom_mem[a]);
         end
      end
   endfunction

   task automatic load_table(input logic [15:0] t[$], input logic [15:0] fill);
      for (int i = 0; i < 256; i++) begin
         rom_mem[i]   = (i < t.size()) ? t[i] : fill;
         nack_mask[i] = 1'b0;
      end
   endtask

   task automatic pulse_start(output int s_edge);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1;
      s_edge = cyc;
      start  = 1'b0;
   endtask

   task automatic wait_end(input string tag, output int end_cyc);
      end_cyc = -1;
      for (int i = 0; i < 4000 && end_cyc < 0; i++) begin
         @(negedge clk);
         if (done || error) end_cyc = cyc;
      end
      check({tag, "_finish"}, 32'(end_cyc >= 0), 1);
   endtask

   task automatic clear_run();
      got_w.delete();
      got_cyc.delete();
      stab_err = 0;
   endtask

   task automatic compare_run(input string tag);
      check({tag, "_nwrites"}, got_w.size(), exp_w.size());
      for (int i = 0; i < exp_w.size(); i++)
         check($sformatf("%s_w%0d", tag, i), (i < got_w.size()) ? got_w[i] : 16'hDEAD, exp_w[i]);
      check({tag, "_done"}, done, !exp_err);
      check({tag, "_error"}, error, exp_err);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_addr"}, rom_addr, exp_addr);
      check({tag, "_stable"}, stab_err, 0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_addr"}, rom_addr, 0);
      check({tag, "_start"}, sccb_start, 0);
      check({tag, "_regval"}, {sccb_reg, sccb_val}, 0);
      check({tag, "_flags"}, {busy, done, error}, 0);
   endtask

   initial begin
      logic [15:0] t[$];
      int          s, e, p, n, cnt;
      foreach (rom_mem[i]) begin rom_mem[i] = 16'hFFFF; nack_mask[i] = 1'b0; end

      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      check("rst_id", sccb_id, 8'h42);
      rst_n = 1'b1;

      // Directed: writes around a delay marker, with exact timing
      t = {16'h1280, 16'hFFF0, 16'h1204, 16'hFFFF};
      load_table(t, 16'hFFFF);
      clear_run(); build_model();
      pulse_start(s);
      wait_end("t1", e);
      compare_run("t1");
      if (got_cyc.size() == 2) begin
         check("t1_first_lat", got_cyc[0] - s, 3);
         check("t1_delay_gap", got_cyc[1] - got_cyc[0], 5 + 3 + DC);
         check("t1_done_lat", e - got_cyc[1], 5);
      end else begin
         check("t1_pulse_count", got_cyc.size(), 2);
      end

      // Terminator at entry 0
      t = {16'hFFFF};
      load_table(t, 16'h1111);
      clear_run(); build_model();
      pulse_start(s);
      wait_end("t2", e);
      check("t2_latency_le3", 32'((e - s) <= 3), 1);
      compare_run("t2");

      // Master not ready for 20 cycles
      t = {16'h1280, 16'h3344, 16'hFFFF};
      load_table(t, 16'hFFFF);
      clear_run(); build_model();
      sccb_ready = 1'b0;
      pulse_start(s);
      repeat (20) @(negedge clk);
      check("t3_no_start", got_w.size(), 0);
      check("t3_latched", {sccb_reg, sccb_val}, 16'h1280);
      check("t3_busy", busy, 1);
      sccb_ready = 1'b1;
      wait_end("t3", e);
      compare_run("t3");

      // Start while busy is ignored
      t = {16'h1280, 16'hFFF0, 16'h1204, 16'hFFFF};
      load_table(t, 16'hFFFF);
      clear_run(); build_model();
      pulse_start(s);
      for (int i = 0; i < 100 && got_w.size() == 0; i++) @(negedge clk);
      pulse_start(s);
      wait_end("t4", e);
      compare_run("t4");

      // Reset in the middle of the delay wait
      clear_run();
      pulse_start(s);
      for (int i = 0; i < 100 && got_w.size() == 0; i++) @(negedge clk);
      p = (got_cyc.size() > 0) ? got_cyc[0] : cyc;
      while (cyc < p + 6) @(negedge clk);
      check("t4r_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      check_reset_vals("t4r");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("t4r_idle_after", {busy, done, 8'(got_w.size())}, 10'd1);

      // No terminator: all 256 entries written, no wrap
      t = {};
      load_table(t, 16'h0101);
      clear_run(); build_model();
      pulse_start(s);
      wait_end("t5", e);
      compare_run("t5");

      // Entry 0 always NACKs
      t = {16'h1280, 16'h3344, 16'hFFFF};
      load_table(t, 16'hFFFF);
      nack_mask[8'h12] = 1'b1;
      clear_run(); build_model();
      pulse_start(s);
      wait_end("t6", e);
      compare_run("t6");
      cnt = 0;
      foreach (got_w[i]) if (got_w[i] == 16'h1280) cnt++;
`ifdef CFG_SEQ_RETRY_EN
      check("t6_pulses_1280", cnt, MAX_RETRY + 1);
`else
      check("t6_pulses_1280", cnt, 1);
`endif

      // Randomized tables, master latency and NACKing registers
      for (int it = 0; it < 12; it++) begin
         t = {};
         n = $urandom_range(1, 12);
         for (int i = 0; i < n; i++)
            t.push_back(($urandom_range(0, 5) == 0) ? 16'hFFF0 : 16'($urandom));
         t.push_back(16'hFFFF);
         load_table(t, 16'($urandom));
         if ($urandom_range(0, 2) == 0) nack_mask[t[$urandom_range(0, n - 1)][15:8]] = 1'b1;
         ack_lat = $urandom_range(0, 3);
         clear_run(); build_model();
         pulse_start(s);
         wait_end($sformatf("rnd%0d", it), e);
         compare_run($sformatf("rnd%0d", it));
      end
      ack_lat = 0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
